// File: rtl/l1_i_refill_if.sv
// l1_i_refill_if: controller-side miss handshake and L2 request/beat bus of the I-cache refill unit
interface l1_i_refill_if #(
    parameter int TAG_W  = 52,
    parameter int IDX_W  = 6,
    parameter int OFF_W  = 6,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 8
);
    logic                            read_L1_L2;
    logic [TAG_W-1:0]                tag;
    logic [IDX_W-1:0]                index;
    logic                            flush;
    logic                            l2_req_valid;
    logic [TAG_W+IDX_W+OFF_W-1:0]    l2_req_addr;
    logic                            l2_req_ready;
    logic                            l2_rvalid;
    logic [BEAT_W-1:0]               l2_rdata;
    logic                            l2_rlast;
    logic                            ready_L2_L1;
    logic [BEAT_W*BEATS-1:0]         refill_line;
    logic                            busy;
    logic                            proto_err;

    modport master (
        input  read_L1_L2, tag, index, flush, l2_req_ready, l2_rvalid, l2_rdata, l2_rlast,
        output l2_req_valid, l2_req_addr, ready_L2_L1, refill_line, busy, proto_err
    );

    modport slave (
        output read_L1_L2, tag, index, flush, l2_req_ready, l2_rvalid, l2_rdata, l2_rlast,
        input  l2_req_valid, l2_req_addr, ready_L2_L1, refill_line, busy, proto_err
    );
endinterface

// File: rtl/l1_i_refill_unit.sv
// l1_i_refill_unit: turns an I-cache miss into one line request to L2, gathers the beats and returns the line
module l1_i_refill_unit #(
    parameter int TAG_W  = 52,
    parameter int IDX_W  = 6,
    parameter int OFF_W  = 6,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 8
) (
    input  logic            clk,
    input  logic            rst,
    l1_i_refill_if.master   bus
);
    localparam int LINE_W = BEAT_W * BEATS;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int ADDR_W = TAG_W + IDX_W + OFF_W;

    typedef enum logic [2:0] {IDLE, REQ, FILL, RESP, HOLD} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    beat_cnt_q;
    logic                drop_q;
    logic [LINE_W-1:0]   line_q;
    logic                req_valid_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                rdy_q;
    logic                busy_q;
    logic                err_q;

    assign bus.l2_req_valid = req_valid_q;
    assign bus.l2_req_addr  = addr_q;
    assign bus.ready_L2_L1  = rdy_q;
    assign bus.refill_line  = line_q;
    assign bus.busy         = busy_q;
    assign bus.proto_err    = err_q;

    // Refill FSM; every output is a register updated with the state it belongs to
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            drop_q      <= 1'b0;
            line_q      <= '0;
            req_valid_q <= 1'b0;
            addr_q      <= '0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (bus.l2_rvalid && state_q != FILL) err_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    drop_q <= 1'b0;
                    if (bus.read_L1_L2 && !bus.flush) begin
                        addr_q      <= {bus.tag, bus.index, {OFF_W{1'b0}}};
                        req_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.flush) drop_q <= 1'b1;
                    if (bus.l2_req_ready) begin
                        req_valid_q <= 1'b0;
                        beat_cnt_q  <= '0;
                        state_q     <= FILL;
                    end
                end
                FILL: begin
                    if (bus.flush) drop_q <= 1'b1;
                    if (bus.l2_rvalid) begin
                        line_q[int'(beat_cnt_q)*BEAT_W +: BEAT_W] <= bus.l2_rdata;
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (bus.l2_rlast != (beat_cnt_q == CNT_W'(BEATS-1))) err_q <= 1'b1;
                        if (beat_cnt_q == CNT_W'(BEATS-1)) begin
                            rdy_q   <= !(drop_q || bus.flush);
                            state_q <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.flush) drop_q <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    drop_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l1_i_refill_unit.sv
// tb_l1_i_refill_unit: table-driven basic miss plus directed multi-cycle corner sequences
module tb_l1_i_refill_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   pulses = 0;
    int   reqs = 0;

    always #5 clk = ~clk;

    l1_i_refill_if bus ();

    l1_i_refill_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Independent event counters: ready pulses and accepted L2 requests
    always @(posedge clk) begin
        if (!rst && bus.ready_L2_L1) pulses <= pulses + 1;
        if (!rst && bus.l2_req_valid && bus.l2_req_ready) reqs <= reqs + 1;
    end

    typedef struct {
        logic        rq;
        logic        rr;
        logic        rv;
        logic        rl;
        logic [63:0] data;
        logic        e_val;
        logic        e_rdy;
        logic        e_busy;
    } vec_t;

    vec_t tv [13];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.read_L1_L2   = 1'b0;
        bus.flush        = 1'b0;
        bus.l2_req_ready = 1'b0;
        bus.l2_rvalid    = 1'b0;
        bus.l2_rdata     = '0;
        bus.l2_rlast     = 1'b0;
    endtask

    task automatic full_miss(input logic [51:0] t, input logic [5:0] ix, input logic [63:0] base, input string nm);
        logic [511:0] exp;
        int p0;
        int r0;
        p0 = pulses;
        r0 = reqs;
        bus.read_L1_L2 = 1'b1;
        bus.tag = t;
        bus.index = ix;
        cyc();
        chk({nm, "_addr"}, 512'(bus.l2_req_addr), 512'({t, ix, 6'b0}));
        bus.l2_req_ready = 1'b1;
        cyc();
        bus.l2_req_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.l2_rvalid = 1'b1;
            bus.l2_rdata = base + 64'(k);
            bus.l2_rlast = (k == 7);
            exp[k*64 +: 64] = base + 64'(k);
            cyc();
        end
        bus.l2_rvalid = 1'b0;
        bus.l2_rlast = 1'b0;
        chk({nm, "_ready"}, 512'(bus.ready_L2_L1), 512'(1));
        chk({nm, "_line"}, bus.refill_line, exp);
        cyc();
        bus.read_L1_L2 = 1'b0;
        cyc();
        chk({nm, "_busy_end"}, 512'(bus.busy), 512'(0));
        chk({nm, "_pulses"}, 512'(pulses - p0), 512'(1));
        chk({nm, "_reqs"}, 512'(reqs - r0), 512'(1));
    endtask

    initial begin
        logic [511:0] exp;
        int p0;
        int r0;
        idle_inputs();
        bus.tag = 52'h1;
        bus.index = 6'd3;

        // Table of the basic miss, one record per cycle, expected outputs seen in the next cycle
        tv[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
        tv[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 8; k++)
            tv[2+k] = '{1'b1, 1'b0, 1'b1, (k == 7), 64'hA0 + 64'(k), 1'b0, (k == 7), 1'b1};
        tv[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1};
        tv[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0};
        tv[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0};

        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_val", 512'(bus.l2_req_valid), 512'(0));
        chk("rst_addr", 512'(bus.l2_req_addr), 512'(0));
        chk("rst_ready", 512'(bus.ready_L2_L1), 512'(0));
        chk("rst_line", bus.refill_line, 512'(0));
        chk("rst_busy", 512'(bus.busy), 512'(0));
        chk("rst_err", 512'(bus.proto_err), 512'(0));

        r0 = reqs;
        p0 = pulses;
        for (int i = 0; i < 13; i++) begin
            bus.read_L1_L2   = tv[i].rq;
            bus.l2_req_ready = tv[i].rr;
            bus.l2_rvalid    = tv[i].rv;
            bus.l2_rlast     = tv[i].rl;
            bus.l2_rdata     = tv[i].data;
            cyc();
            chk($sformatf("tv%0d_val", i), 512'(bus.l2_req_valid), 512'(tv[i].e_val));
            chk($sformatf("tv%0d_rdy", i), 512'(bus.ready_L2_L1), 512'(tv[i].e_rdy));
            chk($sformatf("tv%0d_busy", i), 512'(bus.busy), 512'(tv[i].e_busy));
            if (i == 0) chk("basic_addr", 512'(bus.l2_req_addr), 512'(64'h10C0));
            if (i == 9) begin
                chk("basic_line_lo", 512'(bus.refill_line[63:0]), 512'(64'hA0));
                chk("basic_line_hi", 512'(bus.refill_line[511:448]), 512'(64'hA7));
            end
        end
        idle_inputs();
        chk("basic_one_req", 512'(reqs - r0), 512'(1));
        chk("basic_one_pulse", 512'(pulses - p0), 512'(1));
        chk("basic_err", 512'(bus.proto_err), 512'(0));

        // Flush in the same cycle as the request blocks the start
        bus.read_L1_L2 = 1'b1;
        bus.flush = 1'b1;
        cyc();
        chk("flush_idle_busy", 512'(bus.busy), 512'(0));
        chk("flush_idle_val", 512'(bus.l2_req_valid), 512'(0));
        idle_inputs();
        cyc();

        // Request stall then gapped beats
        p0 = pulses;
        bus.read_L1_L2 = 1'b1;
        bus.tag = 52'hABCDE;
        bus.index = 6'd17;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d_val", i), 512'(bus.l2_req_valid), 512'(1));
            chk($sformatf("stall%0d_addr", i), 512'(bus.l2_req_addr), 512'({52'hABCDE, 6'd17, 6'b0}));
            cyc();
        end
        bus.l2_req_ready = 1'b1;
        cyc();
        bus.l2_req_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.l2_rvalid = 1'b1;
            bus.l2_rdata = 64'hDEAD_0000_0000_0000 | 64'(k * 3);
            bus.l2_rlast = (k == 7);
            exp[k*64 +: 64] = 64'hDEAD_0000_0000_0000 | 64'(k * 3);
            cyc();
            bus.l2_rvalid = 1'b0;
            bus.l2_rlast = 1'b0;
            if (k < 7) cyc();
        end
        chk("gap_ready", 512'(bus.ready_L2_L1), 512'(1));
        chk("gap_line", bus.refill_line, exp);
        cyc();
        bus.read_L1_L2 = 1'b0;
        cyc();
        chk("gap_busy", 512'(bus.busy), 512'(0));
        chk("gap_pulses", 512'(pulses - p0), 512'(1));
        chk("gap_err", 512'(bus.proto_err), 512'(0));

        // Flush after beat 4: drained, no pulse
        p0 = pulses;
        bus.read_L1_L2 = 1'b1;
        bus.tag = 52'h5;
        bus.index = 6'd9;
        cyc();
        bus.l2_req_ready = 1'b1;
        cyc();
        bus.l2_req_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) begin
                bus.l2_rvalid = 1'b0;
                bus.flush = 1'b1;
                bus.read_L1_L2 = 1'b0;
                cyc();
                bus.flush = 1'b0;
            end
            bus.l2_rvalid = 1'b1;
            bus.l2_rdata = 64'h77 + 64'(k);
            bus.l2_rlast = (k == 7);
            cyc();
        end
        bus.l2_rvalid = 1'b0;
        bus.l2_rlast = 1'b0;
        chk("flush_no_ready", 512'(bus.ready_L2_L1), 512'(0));
        chk("flush_busy_resp", 512'(bus.busy), 512'(1));
        for (int i = 0; i < 8 && bus.busy; i++) cyc();
        chk("flush_busy_drop", 512'(bus.busy), 512'(0));
        chk("flush_pulses", 512'(pulses - p0), 512'(0));
        chk("flush_err", 512'(bus.proto_err), 512'(0));
        full_miss(52'hF00D, 6'd63, 64'h1234_5678_0000_0000, "after_flush");

        // rlast on beat 5 and missing on beat 7
        p0 = pulses;
        bus.read_L1_L2 = 1'b1;
        bus.tag = 52'h2;
        bus.index = 6'd1;
        cyc();
        bus.l2_req_ready = 1'b1;
        cyc();
        bus.l2_req_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.l2_rvalid = 1'b1;
            bus.l2_rdata = 64'hC0 + 64'(k);
            bus.l2_rlast = (k == 5);
            cyc();
            if (k == 4) chk("err_before", 512'(bus.proto_err), 512'(0));
            if (k == 5) chk("err_early_last", 512'(bus.proto_err), 512'(1));
        end
        bus.l2_rvalid = 1'b0;
        bus.l2_rlast = 1'b0;
        chk("err_ready", 512'(bus.ready_L2_L1), 512'(1));
        chk("err_line_hi", 512'(bus.refill_line[511:448]), 512'(64'hC7));
        cyc();
        bus.read_L1_L2 = 1'b0;
        cyc();
        chk("err_pulses", 512'(pulses - p0), 512'(1));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("err_cleared", 512'(bus.proto_err), 512'(0));
        bus.l2_rvalid = 1'b1;
        cyc();
        bus.l2_rvalid = 1'b0;
        chk("stray_err", 512'(bus.proto_err), 512'(1));
        chk("stray_busy", 512'(bus.busy), 512'(0));
        cyc();
        cyc();
        chk("stray_sticky", 512'(bus.proto_err), 512'(1));

        // Reset during beat 3
        p0 = pulses;
        bus.read_L1_L2 = 1'b1;
        bus.tag = 52'h3;
        bus.index = 6'd2;
        cyc();
        bus.l2_req_ready = 1'b1;
        cyc();
        bus.l2_req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.l2_rvalid = 1'b1;
            bus.l2_rdata = 64'hE0 + 64'(k);
            cyc();
        end
        bus.l2_rdata = 64'hE3;
        rst = 1'b1;
        cyc();
        chk("mid_rst_val", 512'(bus.l2_req_valid), 512'(0));
        chk("mid_rst_addr", 512'(bus.l2_req_addr), 512'(0));
        chk("mid_rst_ready", 512'(bus.ready_L2_L1), 512'(0));
        chk("mid_rst_line", bus.refill_line, 512'(0));
        chk("mid_rst_busy", 512'(bus.busy), 512'(0));
        chk("mid_rst_err", 512'(bus.proto_err), 512'(0));
        rst = 1'b0;
        idle_inputs();
        cyc();
        chk("mid_rst_no_pulse", 512'(pulses - p0), 512'(0));
        full_miss(52'hBEEF, 6'd5, 64'h9000_0000_0000_0010, "after_rst");
        chk("final_err", 512'(bus.proto_err), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
